// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, start/busy/done handshake.
// Optional build macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               hi_sel_q, hi_sel_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_step, div_step, mul_full, mul_signed;
    logic [WIDTH-1:0]   mul_res, div_sel, div_res;

    assign a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sa       = a_signed & op_a[WIDTH-1];
    assign sb       = b_signed & op_b[WIDTH-1];
    assign mag_a_in = sa ? -op_a : op_a;
    assign mag_b_in = sb ? -op_b : op_b;
    assign div_zero = (op_b == '0);
    assign div_ovf  = b_signed && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend shifting out / quotient shifting in}.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, mag_b_q};
    assign div_step  = div_trial[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
    assign mul_full = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};
`else
    assign mul_full = mul_step;
`endif

    assign mul_signed = neg_q ? -mul_full : mul_full;
    assign mul_res    = hi_sel_q ? mul_signed[2*WIDTH-1:WIDTH] : mul_signed[WIDTH-1:0];
    assign div_sel    = hi_sel_q ? div_step[2*WIDTH-1:WIDTH] : div_step[WIDTH-1:0];
    assign div_res    = neg_q ? -div_sel : div_sel;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_sel_d = hi_sel_q;
        neg_d    = neg_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hi_sel_d = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
                    neg_d    = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
                    mag_a_d  = mag_a_in;
                    mag_b_d  = mag_b_in;
                    cnt_d    = '0;
                    if (!funct3[2]) begin
                        state_d = S_MUL;
                        acc_d   = {{WIDTH{1'b0}}, mag_b_in};
                    end else if (div_zero) begin
                        state_d  = S_DONE;
                        result_d = funct3[1] ? op_a : '1;
                    end else if (div_ovf) begin
                        state_d  = S_DONE;
                        result_d = funct3[1] ? '0 : op_a;
                    end else begin
                        state_d = S_DIV;
                        acc_d   = {{WIDTH{1'b0}}, mag_a_in};
                    end
                end
            end
            S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                state_d  = S_DONE;
                result_d = mul_res;
`else
                acc_d = mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d  = S_DONE;
                    result_d = mul_res;
                end
`endif
            end
            S_DIV: begin
                acc_d = div_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d  = S_DONE;
                    result_d = div_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_sel_q <= 1'b0;
            neg_q    <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_sel_q <= hi_sel_d;
            neg_q    <= neg_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
